jk_bank_arbiter: RTL and testbench

- Shared bank of NUM_CELLS JK storage cells, accessed by NUM_REQ requesters.
- Each requester issues JK commands (HOLD/CLEAR/SET/TOGGLE) to one cell, addressed by index, over a valid/ready handshake.
- A round-robin arbiter grants one command per cycle. The block applies the command and returns the cell's old and new value one cycle later.
- Sits between requester agents and the JK cell storage. It is the only writer of the bank.

---
 rtl/jk_bank_pkg.sv | 32 +++
 rtl/jk_bank_arbiter_rr_arbiter.sv | 37 +++
 rtl/jk_bank_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg
//   Shared types and helpers for the JK bank arbiter.
//   jk_op_e     : {j,k} command encoding applied to one bank cell
//   arb_state_e : arbiter FSM states (LOCKED only reachable with JKB_LOCK_EN)
//   jk_next()   : next value of a JK cell given its current value and command
package jk_bank_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_SET  = 2'b10,
    OP_TOG  = 2'b11
  } jk_op_e;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic jk_next(input logic q, input jk_op_e op);
    logic q_n;
    case (op)
      OP_HOLD: q_n = q;
      OP_CLR:  q_n = 1'b0;
      OP_SET:  q_n = 1'b1;
      OP_TOG:  q_n = ~q;
      default: q_n = q;
    endcase
    return q_n;
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Scans req starting at ptr, wrapping
//   modulo N, and grants the first requester found.
//   Ports:
//     req : N-bit request vector
//     ptr : highest-priority position for this cycle
//     gnt : one-hot grant, zero when no request is present
//     idx : binary index of the granted requester (0 when gnt is zero)
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
//   Bank of NUM_CELLS JK cells shared by NUM_REQ requesters. One command is
//   granted per cycle in round-robin order; the bank bit and the response
//   (old value, new value, one-hot requester strobe) update on the accept edge.
//   Optional macro JKB_LOCK_EN adds a req_lock input that lets a winner keep
//   the bank for up to LOCK_MAX consecutive grants.
//   Ports:
//     clk, reset : rising-edge clock, synchronous active-high reset
//     clr_all    : synchronous bank clear, blocks all grants that cycle
//     req_valid  : per-requester command valid
//     req_ready  : per-requester accept (combinational, one-hot or zero)
//     req_op     : per-requester {j,k} command, 2 bits each
//     req_idx    : per-requester target cell index, IDX_W bits each
//     req_lock   : per-requester lock request (JKB_LOCK_EN only)
//     rsp_valid  : one-hot response strobe, one cycle after accept
//     rsp_prev   : cell value before the accepted command
//     rsp_q      : cell value after the accepted command
//     q_bank     : registered value of every cell
//
//   state  | meaning
//   ARB    | plain round-robin over all requesters
//   LOCKED | only the lock owner can be granted (JKB_LOCK_EN only)
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_CELLS = 8,
  parameter int IDX_W     = $clog2(NUM_CELLS),
  parameter int LOCK_MAX  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_all,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [IDX_W*NUM_REQ-1:0] req_idx,
`ifdef JKB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic                     rsp_prev,
  output logic                     rsp_q,
  output logic [NUM_CELLS-1:0]     q_bank
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_CELLS < 2 || NUM_CELLS > 64 ||
      IDX_W < $clog2(NUM_CELLS) || LOCK_MAX < 1) begin : g_param_chk
    $error("jk_bank_arbiter: parameter out of supported range");
  end

  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   arb_req;
  logic [NUM_REQ-1:0]   gnt;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     win_inc;
  logic                 accept;
  logic [1:0]           sel_op;
  logic [IDX_W-1:0]     sel_idx;
  logic                 in_range;
  logic                 old_bit;
  logic                 new_bit;
  logic [NUM_CELLS-1:0] bank_next;

`ifdef JKB_LOCK_EN
  localparam int LCNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e        state;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  owner_inc;
  logic [LCNT_W-1:0] lock_cnt;

  // While locked, everyone but the owner is masked out before arbitration.
  always_comb begin
    arb_req = req_valid;
    if (state == LOCKED) begin
      arb_req = req_valid & (NUM_REQ'(1) << owner);
    end
  end

  assign owner_inc = (int'(owner) == NUM_REQ - 1) ? '0 : owner + PTR_W'(1);
`else
  assign arb_req = req_valid;
`endif

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win)
  );

  assign req_ready = (reset || clr_all) ? '0 : gnt;
  assign accept    = |req_ready;
  assign win_inc   = (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);

  // Index decode is done by compare so that indices wider than the bank
  // (out-of-range commands) simply match no cell.
  always_comb begin
    sel_op    = req_op[2*int'(win) +: 2];
    sel_idx   = req_idx[IDX_W*int'(win) +: IDX_W];
    in_range  = 1'b0;
    old_bit   = 1'b0;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (sel_idx == IDX_W'(c)) begin
        in_range = 1'b1;
        old_bit  = q_bank[c];
      end
    end
    new_bit   = jk_next(old_bit, jk_op_e'(sel_op));
    bank_next = q_bank;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (sel_idx == IDX_W'(c)) begin
        bank_next[c] = new_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_bank    <= '0;
      rsp_valid <= '0;
      rsp_prev  <= 1'b0;
      rsp_q     <= 1'b0;
      rr_ptr    <= '0;
`ifdef JKB_LOCK_EN
      state     <= ARB;
      owner     <= '0;
      lock_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      if (clr_all) begin
        q_bank <= '0;
      end else if (accept) begin
        q_bank    <= bank_next;
        rsp_valid <= gnt;
        rsp_prev  <= in_range & old_bit;
        rsp_q     <= in_range & new_bit;
        rr_ptr    <= win_inc;
      end
`ifdef JKB_LOCK_EN
      case (state)
        ARB: begin
          if (accept && req_lock[win]) begin
            owner    <= win;
            lock_cnt <= LCNT_W'(1);
            // A one-grant lock budget is already spent by this accept.
            if (LOCK_MAX > 1) begin
              state <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (clr_all || !req_lock[owner]) begin
            state    <= ARB;
            lock_cnt <= '0;
            rr_ptr   <= owner_inc;
          end else if (accept) begin
            if (int'(lock_cnt) + 1 >= LOCK_MAX) begin
              state    <= ARB;
              lock_cnt <= '0;
              rr_ptr   <= owner_inc;
            end else begin
              lock_cnt <= lock_cnt + LCNT_W'(1);
            end
          end
        end
        default: state <= ARB;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter
//   Directed scenarios plus a randomized run checked against a small
//   behavioural model of the bank and the round-robin pointer.
//   IDX_W is widened to 4 so that out-of-range indices (8..15) can be driven.
module tb_jk_bank_arbiter;

  localparam int NR = 4;
  localparam int NC = 8;
  localparam int IW = 4;
  localparam int LM = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr_all;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [2*NR-1:0] req_op;
  logic [IW*NR-1:0] req_idx;
`ifdef JKB_LOCK_EN
  logic [NR-1:0] req_lock;
`endif
  logic [NR-1:0] rsp_valid;
  logic          rsp_prev;
  logic          rsp_q;
  logic [NC-1:0] q_bank;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [NC-1:0] m_bank;
  int            m_ptr;
  int            m_win;
  logic [NR-1:0] exp_ready;
  logic [NR-1:0] exp_rsp_valid;
  logic          exp_prev;
  logic          exp_q;

  always #5 clk = ~clk;

  jk_bank_arbiter #(
    .NUM_REQ   (NR),
    .NUM_CELLS (NC),
    .IDX_W     (IW),
    .LOCK_MAX  (LM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clr_all   (clr_all),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_idx   (req_idx),
`ifdef JKB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_prev  (rsp_prev),
    .rsp_q     (rsp_q),
    .q_bank    (q_bank)
  );

  // Winner for the current inputs: first valid requester at or after m_ptr.
  task automatic model_predict();
    int c;
    m_win = -1;
    if (!reset && !clr_all) begin
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (m_win < 0 && req_valid[c]) m_win = c;
      end
    end
    exp_ready = (m_win >= 0) ? (NR'(1) << m_win) : '0;
  endtask

  // Effect of the clock edge on bank, pointer and response.
  task automatic model_commit();
    logic [1:0] op;
    int ix;
    logic p, n;
    if (reset) begin
      m_bank = '0; m_ptr = 0; exp_rsp_valid = '0; exp_prev = 1'b0; exp_q = 1'b0;
    end else if (clr_all) begin
      m_bank = '0; exp_rsp_valid = '0;
    end else if (m_win >= 0) begin
      op = req_op[2*m_win +: 2];
      ix = int'(req_idx[IW*m_win +: IW]);
      if (ix < NC) begin
        p = m_bank[ix];
        if (op == 2'd0) n = p;
        else if (op == 2'd1) n = 1'b0;
        else if (op == 2'd2) n = 1'b1;
        else n = ~p;
        m_bank[ix] = n;
        exp_prev = p;
        exp_q = n;
      end else begin
        exp_prev = 1'b0;
        exp_q = 1'b0;
      end
      exp_rsp_valid = NR'(1) << m_win;
      m_ptr = (m_win + 1) % NR;
    end else begin
      exp_rsp_valid = '0;
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic [1:0] op, input int ix);
    req_valid[r] = v;
    req_op[2*r +: 2] = op;
    req_idx[IW*r +: IW] = IW'(ix);
  endtask

  task automatic pre();
    #1;
    model_predict();
  endtask

  task automatic post();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; clr_all = 1'b0; req_valid = '0;
`ifdef JKB_LOCK_EN
    req_lock = '0;
`endif
    pre();
    post();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; clr_all = 1'b0; req_valid = '1;
    pre();
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    post();
    vectors++;
    if (q_bank !== 8'h00 || rsp_valid !== 4'b0000 || rsp_prev !== 1'b0 || rsp_q !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got bank=%h rsp_valid=%b prev=%b q=%b expected all zero",
               q_bank, rsp_valid, rsp_prev, rsp_q);
    end
  endtask

  task automatic test_single_set();
    @(negedge clk);
    reset = 1'b0; req_valid = '0;
    set_req(0, 1'b1, 2'b10, 3);
    pre();
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL set_ready: got %b expected 0001", req_ready);
    end
    post();
    vectors++;
    if (rsp_valid !== 4'b0001 || rsp_prev !== 1'b0 || rsp_q !== 1'b1 || q_bank !== 8'h08) begin
      miscompares++;
      $display("FAIL set_rsp: got rsp_valid=%b prev=%b q=%b bank=%h expected 0001 0 1 08",
               rsp_valid, rsp_prev, rsp_q, q_bank);
    end
  endtask

  task automatic test_rotation();
    int exp_win[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_bank[5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
    do_reset();
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, 2'b11, r);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      pre();
      vectors++;
      if (req_ready !== (NR'(1) << exp_win[k])) begin
        miscompares++;
        $display("FAIL rotation_ready[%0d]: got %b expected requester %0d", k, req_ready, exp_win[k]);
      end
      post();
      vectors++;
      if (q_bank !== exp_bank[k] || rsp_valid !== (NR'(1) << exp_win[k])) begin
        miscompares++;
        $display("FAIL rotation_bank[%0d]: got bank=%h rsp_valid=%b expected bank=%h requester %0d",
                 k, q_bank, rsp_valid, exp_bank[k], exp_win[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(1, 1'b1, 2'b11, 5);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      pre();
      vectors++;
      if (req_ready !== 4'b0010) begin
        miscompares++; $display("FAIL b2b_ready[%0d]: got %b expected 0010", k, req_ready);
      end
      post();
      vectors++;
      if (rsp_valid !== 4'b0010 || rsp_prev !== (k == 1) || rsp_q !== (k == 0)) begin
        miscompares++;
        $display("FAIL b2b_rsp[%0d]: got rsp_valid=%b prev=%b q=%b expected 0010 %0d %0d",
                 k, rsp_valid, rsp_prev, rsp_q, (k == 1), (k == 0));
      end
    end
    vectors++;
    if (q_bank[5] !== 1'b0) begin
      miscompares++; $display("FAIL b2b_bank: got bit5=%b expected 0", q_bank[5]);
    end
  endtask

  task automatic test_clr_all();
    do_reset();
    for (int c = 0; c < NC; c++) begin
      if (c > 0) @(negedge clk);
      set_req(0, 1'b1, 2'b10, c);
      pre();
      post();
    end
    vectors++;
    if (q_bank !== 8'hFF) begin
      miscompares++; $display("FAIL clr_fill: got %h expected ff", q_bank);
    end
    @(negedge clk);
    req_valid = '0;
    set_req(2, 1'b1, 2'b10, 6);
    clr_all = 1'b1;
    pre();
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL clr_ready: got %b expected 0000", req_ready);
    end
    post();
    vectors++;
    if (q_bank !== 8'h00 || rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL clr_bank: got bank=%h rsp_valid=%b expected 00 0000", q_bank, rsp_valid);
    end
    @(negedge clk);
    clr_all = 1'b0;
    pre();
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++; $display("FAIL clr_after_ready: got %b expected 0100", req_ready);
    end
    post();
    vectors++;
    if (rsp_valid !== 4'b0100 || q_bank !== 8'h40) begin
      miscompares++;
      $display("FAIL clr_after_rsp: got rsp_valid=%b bank=%h expected 0100 40", rsp_valid, q_bank);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    req_valid = '0;
    set_req(3, 1'b1, 2'b10, 9);
    pre();
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++; $display("FAIL oor_ready: got %b expected 1000", req_ready);
    end
    post();
    vectors++;
    if (rsp_valid !== 4'b1000 || rsp_prev !== 1'b0 || rsp_q !== 1'b0 || q_bank !== 8'h40) begin
      miscompares++;
      $display("FAIL oor_rsp: got rsp_valid=%b prev=%b q=%b bank=%h expected 1000 0 0 40",
               rsp_valid, rsp_prev, rsp_q, q_bank);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    set_req(0, 1'b1, 2'b10, 0);
    pre();
    post();
    @(negedge clk);
    reset = 1'b1; clr_all = 1'b1; req_valid = '1;
    pre();
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL rstclr_ready: got %b expected 0000", req_ready);
    end
    post();
    vectors++;
    if (q_bank !== 8'h00 || rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstclr_bank: got bank=%h rsp_valid=%b expected 00 0000", q_bank, rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0; clr_all = 1'b0;
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, 2'b00, r);
    pre();
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL rstclr_ptr: got %b expected 0001", req_ready);
    end
    post();
  endtask

  task automatic test_random();
    logic [NR-1:0] acc_prev;
    do_reset();
    acc_prev = '0;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      clr_all = ($urandom_range(0, 15) == 0);
      for (int r = 0; r < NR; r++) begin
        if (req_valid[r] && !acc_prev[r]) begin
          if ($urandom_range(0, 7) == 0) req_valid[r] = 1'b0;
        end else begin
          set_req(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
        end
      end
      pre();
      acc_prev = exp_ready;
      vectors++;
      if (req_ready !== exp_ready) begin
        miscompares++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, req_ready, exp_ready);
      end
      post();
      vectors++;
      if (rsp_valid !== exp_rsp_valid) begin
        miscompares++;
        $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", n, rsp_valid, exp_rsp_valid);
      end
      vectors++;
      if (rsp_prev !== exp_prev || rsp_q !== exp_q) begin
        miscompares++;
        $display("FAIL rand_rsp_data[%0d]: got prev=%b q=%b expected %b %b", n, rsp_prev, rsp_q, exp_prev, exp_q);
      end
      vectors++;
      if (q_bank !== m_bank) begin
        miscompares++; $display("FAIL rand_bank[%0d]: got %h expected %h", n, q_bank, m_bank);
      end
    end
    @(negedge clk);
    req_valid = '0; clr_all = 1'b0;
  endtask

`ifdef JKB_LOCK_EN
  task automatic test_lock();
    logic [NR-1:0] exp_seq[4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    do_reset();
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, 2'b00, r);
    req_lock = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      vectors++;
      if (req_ready !== exp_seq[k]) begin
        miscompares++; $display("FAIL lock_seq[%0d]: got %b expected %b", k, req_ready, exp_seq[k]);
      end
      @(posedge clk);
    end
    do_reset();
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, 2'b00, r);
    req_lock = 4'b0001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL lock_enter: got %b expected 0001", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_lock = '0;
    req_valid = 4'b1110;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++; $display("FAIL lock_reset: got %b expected 0010", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
  endtask
`endif

  initial begin
    reset = 1'b1; clr_all = 1'b0; req_valid = '0; req_op = '0; req_idx = '0;
`ifdef JKB_LOCK_EN
    req_lock = '0;
`endif
    m_bank = '0; m_ptr = 0; m_win = -1;
    exp_ready = '0; exp_rsp_valid = '0; exp_prev = 1'b0; exp_q = 1'b0;
    test_reset();
    test_single_set();
    test_rotation();
    test_back_to_back();
    test_clr_all();
    test_out_of_range();
    test_reset_priority();
    test_random();
`ifdef JKB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
